// File: rtl/sif_stream_fifo_if.sv
// Valid/ready stream bundle: master drives vld/dat, slave answers with rdy.
interface sif_stream_fifo_if #(
    parameter int W = 32
) ();
    logic         vld;
    logic         rdy;
    logic [W-1:0] dat;

    modport master (output vld, output dat, input rdy);
    modport slave  (input vld, input dat, output rdy);
endinterface

// File: rtl/sif_stream_fifo.sv
// First-word-fall-through stream FIFO between the DMA source and the DDR3 write path.
// Handshake flags and fill level are registered from the next-state fill count.
module sif_stream_fifo #(
    parameter int DMA_WIDTH = 32,
    parameter int DEPTH     = 8,
    parameter int AFULL_TH  = 6
) (
    input  logic                   clk,
    input  logic                   rst_n,
    sif_stream_fifo_if.slave       up,
    sif_stream_fifo_if.master      dn,
    output logic [$clog2(DEPTH):0] fill_cnt,
    output logic                   afull
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [DMA_WIDTH-1:0] mem_q [DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] fill_q, fill_d;
    logic          up_rdy_q, dn_vld_q, afull_q;
    logic          empty_w, full_w, push, pop;

    // MSB is the wrap flag: equal pointers mean empty, differing MSBs with equal index mean full
    assign empty_w = (wr_ptr_q == rd_ptr_q);
    assign full_w  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    assign push = up.vld && up_rdy_q && !full_w;
    assign pop  = dn_vld_q && dn.rdy && !empty_w;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        fill_d   = fill_q;
        if (push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        fill_d = fill_q + PW'(push) - PW'(pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fill_q   <= '0;
            up_rdy_q <= 1'b0;
            dn_vld_q <= 1'b0;
            afull_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            fill_q   <= fill_d;
            up_rdy_q <= (fill_d < PW'(DEPTH));
            dn_vld_q <= (fill_d != '0);
            afull_q  <= (fill_d >= PW'(AFULL_TH));
        end
    end

    // Storage carries no reset so it can map onto distributed RAM
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= up.dat;
    end

    // Head word reads straight from storage; forced to zero whenever nothing is valid
    assign dn.dat   = dn_vld_q ? mem_q[rd_ptr_q[AW-1:0]] : '0;
    assign dn.vld   = dn_vld_q;
    assign up.rdy   = up_rdy_q;
    assign fill_cnt = fill_q;
    assign afull    = afull_q;
endmodule

// File: tb/tb_sif_stream_fifo.sv
// Bench for sif_stream_fifo: vector table for fill/drain, hand sequences for
// streaming and reset, and a randomized run against a queue reference model.
module tb_sif_stream_fifo;
    localparam int DEPTH = 8;
    localparam int TH    = 6;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] fill_cnt;
    logic       afull;
    int         tests = 0;
    int         fails = 0;

    sif_stream_fifo_if #(.W(32)) up_if ();
    sif_stream_fifo_if #(.W(32)) dn_if ();

    sif_stream_fifo #(.DMA_WIDTH(32), .DEPTH(DEPTH), .AFULL_TH(TH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .up       (up_if),
        .dn       (dn_if),
        .fill_cnt (fill_cnt),
        .afull    (afull)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        vld;
        logic [31:0] dat;
        logic        rdy;
        logic        e_uprdy;
        logic        e_dnvld;
        logic [31:0] e_dat;
        int          e_fill;
        logic        e_af;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic v, logic [31:0] d, logic r, logic eu,
                                logic ev, logic [31:0] ed, int ef, logic ea);
        vec_t t;
        t.vld = v; t.dat = d; t.rdy = r; t.e_uprdy = eu;
        t.e_dnvld = ev; t.e_dat = ed; t.e_fill = ef; t.e_af = ea;
        return t;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] q[$];
        logic [31:0] prev_dat;
        logic        prev_hold;
        logic        do_push, do_pop;
        int          popped, cyc;

        up_if.vld = 1'b1;
        up_if.dat = 32'hA5A5_0001;
        dn_if.rdy = 1'b0;
        step();
        step();
        chk("rst_up_rdy", 32'(up_if.rdy), 32'd0);
        chk("rst_dn_vld", 32'(dn_if.vld), 32'd0);
        chk("rst_fill",   32'(fill_cnt),  32'd0);
        chk("rst_afull",  32'(afull),     32'd0);
        chk("rst_dn_dat", dn_if.dat,      32'd0);
        rst_n = 1'b1;

        // edge 1 raises up_rdy, edge 2 takes the first word, then drain it
        tbl.push_back(mk(1, 32'hA5A5_0001, 0, 1, 0, 32'h0, 0, 0));
        tbl.push_back(mk(1, 32'hA5A5_0001, 0, 1, 1, 32'hA5A5_0001, 1, 0));
        tbl.push_back(mk(0, 32'h0, 1, 1, 0, 32'h0, 0, 0));
        for (int k = 1; k <= DEPTH; k++)
            tbl.push_back(mk(1, 32'(k), 0, k < DEPTH, 1, 32'h1, k, k >= TH));
        tbl.push_back(mk(1, 32'h9, 0, 0, 1, 32'h1, DEPTH, 1));
        for (int i = 1; i <= DEPTH; i++)
            tbl.push_back(mk(0, 32'h0, 1, 1, i < DEPTH, 32'(i + 1), DEPTH - i, (DEPTH - i) >= TH));

        for (int i = 0; i < tbl.size(); i++) begin
            up_if.vld = tbl[i].vld;
            up_if.dat = tbl[i].dat;
            dn_if.rdy = tbl[i].rdy;
            step();
            $display("[TB] vec %0d vld=%0b dat=%h rdy=%0b -> up_rdy=%0b dn_vld=%0b dn_dat=%h fill=%0d afull=%0b",
                     i, tbl[i].vld, tbl[i].dat, tbl[i].rdy, up_if.rdy, dn_if.vld, dn_if.dat, fill_cnt, afull);
            chk($sformatf("vec%0d_up_rdy", i), 32'(up_if.rdy), 32'(tbl[i].e_uprdy));
            chk($sformatf("vec%0d_dn_vld", i), 32'(dn_if.vld), 32'(tbl[i].e_dnvld));
            chk($sformatf("vec%0d_fill", i),   32'(fill_cnt),  32'(tbl[i].e_fill));
            chk($sformatf("vec%0d_afull", i),  32'(afull),     32'(tbl[i].e_af));
            if (tbl[i].e_dnvld)
                chk($sformatf("vec%0d_dn_dat", i), dn_if.dat, tbl[i].e_dat);
        end

        // continuous streaming across the pointer wrap
        dn_if.rdy = 1'b1;
        for (int k = 0; k < 20; k++) begin
            up_if.vld = 1'b1;
            up_if.dat = 32'h100 + 32'(k);
            step();
            $display("[TB] stream %0d dn_dat=%h fill=%0d", k, dn_if.dat, fill_cnt);
            chk("stream_dn_vld", 32'(dn_if.vld), 32'd1);
            chk("stream_dn_dat", dn_if.dat, 32'h100 + 32'(k));
            chk("stream_fill",   32'(fill_cnt), 32'd1);
        end
        up_if.vld = 1'b0;
        step();
        chk("stream_drain_vld",  32'(dn_if.vld), 32'd0);
        chk("stream_drain_fill", 32'(fill_cnt),  32'd0);

        // randomized traffic against a queue model
        popped = 0;
        cyc = 0;
        prev_hold = 1'b0;
        prev_dat = '0;
        while (popped < 1000 && cyc < 20000) begin
            chk("rnd_fill",   32'(fill_cnt),  32'(q.size()));
            chk("rnd_up_rdy", 32'(up_if.rdy), 32'(q.size() < DEPTH));
            chk("rnd_dn_vld", 32'(dn_if.vld), 32'(q.size() != 0));
            chk("rnd_afull",  32'(afull),     32'(q.size() >= TH));
            chk("rnd_fill_le_depth", 32'(fill_cnt <= 4'(DEPTH)), 32'd1);
            if (q.size() != 0) chk("rnd_dn_dat", dn_if.dat, q[0]);
            if (prev_hold) chk("rnd_hold_stable", dn_if.dat, prev_dat);

            up_if.vld = 1'($urandom_range(0, 1));
            up_if.dat = $urandom;
            dn_if.rdy = 1'($urandom_range(0, 1));
            do_push = up_if.vld && (q.size() < DEPTH);
            do_pop  = (q.size() != 0) && dn_if.rdy;
            prev_hold = (q.size() != 0) && !dn_if.rdy;
            prev_dat = dn_if.dat;
            if (do_pop) begin
                $display("[TB] rnd word %0d %h", popped, q[0]);
                void'(q.pop_front());
                popped++;
            end
            if (do_push) q.push_back(up_if.dat);
            step();
            cyc++;
        end
        if (popped < 1000) chk("rnd_timeout_words", 32'(popped), 32'd1000);

        up_if.vld = 1'b0;
        dn_if.rdy = 1'b1;
        for (int i = 0; i < 12; i++) step();
        chk("pre_rst6_fill", 32'(fill_cnt), 32'd0);

        // fill to 5 then reset mid-operation
        dn_if.rdy = 1'b0;
        for (int k = 0; k < 5; k++) begin
            up_if.vld = 1'b1;
            up_if.dat = 32'hC000 + 32'(k);
            step();
        end
        up_if.vld = 1'b0;
        chk("pre_rst_fill", 32'(fill_cnt), 32'd5);
        #2 rst_n = 1'b0;
        #1;
        $display("[TB] mid reset dn_vld=%0b up_rdy=%0b fill=%0d", dn_if.vld, up_if.rdy, fill_cnt);
        chk("mid_rst_dn_vld", 32'(dn_if.vld), 32'd0);
        chk("mid_rst_up_rdy", 32'(up_if.rdy), 32'd0);
        chk("mid_rst_fill",   32'(fill_cnt),  32'd0);
        chk("mid_rst_afull",  32'(afull),     32'd0);
        step();
        rst_n = 1'b1;
        dn_if.rdy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("post_rst_dn_vld", 32'(dn_if.vld), 32'd0);
            chk("post_rst_fill",   32'(fill_cnt),  32'd0);
        end
        chk("post_rst_up_rdy", 32'(up_if.rdy), 32'd1);
        dn_if.rdy = 1'b0;
        up_if.vld = 1'b1;
        up_if.dat = 32'h0000_BEEF;
        step();
        up_if.vld = 1'b0;
        $display("[TB] post reset push dn_dat=%h fill=%0d", dn_if.dat, fill_cnt);
        chk("post_rst_head_vld", 32'(dn_if.vld), 32'd1);
        chk("post_rst_head_dat", dn_if.dat, 32'h0000_BEEF);
        chk("post_rst_head_fill", 32'(fill_cnt), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
